cla_nibble_subtractor: RTL

Multi-cycle, nibble-serial subtractor that computes D = A − B on 4·NIBBLES-bit operands. It reuses one 4-bit carry-lookahead slice per cycle, with the inter-nibble carry held in a register. It is the inverse-direction companion to the registered 4-bit CLA adder path and sits beside it in the arithmetic datapath. A start/busy/done handshake lets a controller issue wide subtractions without instantiating a full-width adder.

---
 rtl/cla_nibble_subtractor.sv | 136 +++++++++++++
 1 files changed

// File: rtl/cla_nibble_subtractor.sv
// Nibble-serial subtractor: D = A - B computed as A + ~B + 1, one 4-bit
// carry-lookahead slice per cycle, LSB nibble first, carry held in a register.

module cla4_slice (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] s_o,
    output logic       c_o
);
    logic [3:0] g, p;
    logic [4:0] c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    // Every carry is a flat sum-of-products of g/p/c0, no ripple.
    assign c[0] = c_i;
    assign c[1] = g[0] | (p[0] & c_i);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c_i);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c_i);

    assign s_o = p ^ c[3:0];
    assign c_o = c[4];
endmodule

module cla_nibble_subtractor #(
    parameter  int NIBBLES = 4,
    localparam int W       = 4 * NIBBLES,
    localparam int KW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] A_in,
    input  logic [W-1:0] B_in,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] D_out,
    output logic         Bout
);
    typedef enum logic {IDLE = 1'b0, CALC = 1'b1} state_t;

    localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d, wk_q, wk_d, d_q, d_d;
    logic [KW-1:0] k_q, k_d;
    logic          cy_q, cy_d, bout_q, bout_d, done_q, done_d;

    logic [3:0]    sum;
    logic          c4;
    logic [W-1:0]  wk_upd;

    // b_q already holds ~B, so the slice is a plain adder here.
    cla4_slice u_slice (
        .a_i (a_q[k_q*4 +: 4]),
        .b_i (b_q[k_q*4 +: 4]),
        .c_i (cy_q),
        .s_o (sum),
        .c_o (c4)
    );

    always_comb begin
        wk_upd             = wk_q;
        wk_upd[k_q*4 +: 4] = sum;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        wk_d    = wk_q;
        cy_d    = cy_q;
        k_d     = k_q;
        d_d     = d_q;
        bout_d  = bout_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = A_in;
                    b_d     = ~B_in;
                    cy_d    = 1'b1;
                    k_d     = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                wk_d = wk_upd;
                cy_d = c4;
                if (k_q == K_LAST) begin
                    d_d     = wk_upd;
                    bout_d  = ~c4;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            wk_q    <= '0;
            cy_q    <= 1'b0;
            k_q     <= '0;
            d_q     <= '0;
            bout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            wk_q    <= wk_d;
            cy_q    <= cy_d;
            k_q     <= k_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
            done_q  <= done_d;
        end
    end

    assign busy  = (state_q == CALC);
    assign done  = done_q;
    assign D_out = d_q;
    assign Bout  = bout_q;
endmodule
